// File: rtl/booth_mul_sequencer.sv
// Sequencing stage for the 8x8 sequential Booth multiplier.
// Loads operands, holds the multiplier in clear, waits its latency, hands back P.
module booth_mul_sequencer #(
    parameter int BITS           = 8,
    parameter int LATENCY        = 8,
    parameter int MUL_RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    output logic [BITS-1:0]   mul_a,
    output logic [BITS-1:0]   mul_b,
    output logic              mul_reset,
    input  logic [2*BITS-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out_p,
    output logic [15:0]       op_count
);

    localparam int CMAX = (LATENCY > MUL_RST_CYCLES) ? LATENCY : MUL_RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(MUL_RST_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BITS-1:0]   mul_a_q, mul_a_d;
    logic [BITS-1:0]   mul_b_q, mul_b_d;
    logic              mul_rst_q, mul_rst_d;
    logic [2*BITS-1:0] out_p_q, out_p_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       op_cnt_q, op_cnt_d;

    // Ready depends on state only, so no combinational path from in_valid.
    assign in_ready = (state_q == S_IDLE) && reset;

    // Next-state logic for the four-phase operation sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_rst_d   = mul_rst_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
        op_cnt_d    = op_cnt_q;
        case (state_q)
            S_IDLE: begin
                mul_rst_d = 1'b1;
                if (in_valid && in_ready) begin
                    mul_a_d = in_a;
                    mul_b_d = in_b;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == RST_LAST) begin
                    mul_rst_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == LAT_LAST) begin
                    out_p_d     = mul_p;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + 16'd1;
                    mul_rst_d   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mul_rst_d = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any operation and drops a pending product.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_rst_q   <= 1'b1;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
            op_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_rst_q   <= mul_rst_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_reset = mul_rst_q;
    assign out_p     = out_p_q;
    assign out_valid = out_valid_q;
    assign op_count  = op_cnt_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Bench for booth_mul_sequencer with a behavioural multiplier
// that only shows the true product once its latency has elapsed.
module tb_booth_mul_sequencer;

    localparam int LAT  = 8;
    localparam int MRC  = 2;
    localparam int EXPL = MRC + LAT;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_reset;
    logic [15:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic [15:0] op_count;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_count;

    booth_mul_sequencer #(
        .BITS(8),
        .LATENCY(LAT),
        .MUL_RST_CYCLES(MRC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_reset(mul_reset),
        .mul_p(mul_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p(out_p),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    // Multiplier stand-in: garbage until LAT cycles after clear is released.
    int unsigned mcnt;
    always @(posedge clk) begin
        if (mul_reset) begin
            mcnt  <= 0;
            mul_p <= 16'h0000;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 >= LAT - 1)
                mul_p <= ref_prod(mul_a, mul_b);
            else
                mul_p <= ref_prod(mul_a, mul_b) ^ 16'hA5A5 ^ 16'(mcnt);
        end
    end

    task automatic do_accept(input logic [7:0] a, input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (n < 50) begin
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h11;
        in_b = 8'h22;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_in_ready: got %b want 0", in_ready);
            end
            n_vec++;
            if (mul_reset !== 1'b1) begin
                n_miss++;
                $display("FAIL reset_mul_reset: got %b want 1", mul_reset);
            end
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_out_valid: got %b want 0", out_valid);
            end
            n_vec++;
            if (op_count !== 16'd0) begin
                n_miss++;
                $display("FAIL reset_op_count: got %h want 0000", op_count);
            end
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || mul_a !== 8'h00 || mul_b !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_no_accept: rdy=%b a=%h b=%h want 1 00 00",
                     in_ready, mul_a, mul_b);
        end
        exp_count = 16'd0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen;
        int n;
        do_accept(8'h40, 8'h40, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL midrun_accept: got timeout want accept");
        end
        repeat (MRC + 4) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || mul_reset !== 1'b0) begin
            n_miss++;
            $display("FAIL midrun_running: ov=%b mr=%b want 0 0", out_valid, mul_reset);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || mul_reset !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL midrun_idle: rdy=%b mr=%b ov=%b want 1 1 0",
                     in_ready, mul_reset, out_valid);
        end
        n_vec++;
        if (op_count !== exp_count) begin
            n_miss++;
            $display("FAIL midrun_count: got %h want %h", op_count, exp_count);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_miss++;
            $display("FAIL midrun_discard: got out_valid=1 want 0");
        end
        do_accept(8'h05, 8'hFD, ok);
        wait_valid(n);
        n_vec++;
        if (!ok || n != EXPL) begin
            n_miss++;
            $display("FAIL midrun_latency: got %0d want %0d", n, EXPL);
        end
        n_vec++;
        if (out_p !== 16'hFFF1) begin
            n_miss++;
            $display("FAIL midrun_product: got %h want fff1", out_p);
        end
        handshake();
        n_vec++;
        if (out_valid !== 1'b0 || op_count !== exp_count) begin
            n_miss++;
            $display("FAIL midrun_done: ov=%b cnt=%h want 0 %h", out_valid, op_count, exp_count);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        out_ready = 1'b1;
        do_accept(8'h81, 8'h84, ok);
        wait_valid(n);
        n_vec++;
        if (!ok || n != EXPL) begin
            n_miss++;
            $display("FAIL basic_latency: got %0d want %0d", n, EXPL);
        end
        n_vec++;
        if (out_p !== 16'h3D84) begin
            n_miss++;
            $display("FAIL basic_product: got %h want 3d84", out_p);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_vec++;
        if (out_valid !== 1'b0 || op_count !== exp_count) begin
            n_miss++;
            $display("FAIL basic_done: ov=%b cnt=%h want 0 %h", out_valid, op_count, exp_count);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL basic_ready_back: got %b want 1", in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        int n;
        out_ready = 1'b0;
        do_accept(8'h7F, 8'h80, ok);
        wait_valid(n);
        n_vec++;
        if (!ok || n != EXPL) begin
            n_miss++;
            $display("FAIL bp_latency: got %0d want %0d", n, EXPL);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_p !== 16'hC080 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL bp_hold: ov=%b p=%h rdy=%b want 1 c080 0", out_valid, out_p, in_ready);
        end
        handshake();
        n_vec++;
        if (out_valid !== 1'b0 || op_count !== exp_count) begin
            n_miss++;
            $display("FAIL bp_done: ov=%b cnt=%h want 0 %h", out_valid, op_count, exp_count);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (op_count !== exp_count) begin
            n_miss++;
            $display("FAIL bp_count_once: got %h want %h", op_count, exp_count);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        bit bad;
        int n;
        out_ready = 1'b0;
        do_accept(8'h12, 8'h34, ok);
        repeat (MRC + 1) @(posedge clk);
        #1;
        in_a = 8'hEE;
        in_b = 8'h99;
        in_valid = 1'b1;
        bad = 1'b0;
        n = MRC + 1;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0 || mul_a !== 8'h12 || mul_b !== 8'h34)
                bad = 1'b1;
            in_valid = ~in_valid;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        n_vec++;
        if (!ok || n != EXPL) begin
            n_miss++;
            $display("FAIL busy_latency: got %0d want %0d", n, EXPL);
        end
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL busy_operands: a=%h b=%h want 12 34", mul_a, mul_b);
        end
        n_vec++;
        if (out_p !== ref_prod(8'h12, 8'h34)) begin
            n_miss++;
            $display("FAIL busy_product: got %h want %h", out_p, ref_prod(8'h12, 8'h34));
        end
        handshake();
        n_vec++;
        if (in_ready !== 1'b1 || mul_a !== 8'h12 || op_count !== exp_count) begin
            n_miss++;
            $display("FAIL busy_no_same_cycle: rdy=%b a=%h cnt=%h want 1 12 %h",
                     in_ready, mul_a, op_count, exp_count);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (mul_a !== 8'hEE || mul_b !== 8'h99 || in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL busy_next_accept: a=%h b=%h rdy=%b want ee 99 0",
                     mul_a, mul_b, in_ready);
        end
        wait_valid(n);
        n_vec++;
        if (n != EXPL || out_p !== ref_prod(8'hEE, 8'h99)) begin
            n_miss++;
            $display("FAIL busy_second: lat=%0d p=%h want %0d %h",
                     n, out_p, EXPL, ref_prod(8'hEE, 8'h99));
        end
        handshake();
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int d;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] start;
        logic [15:0] want;
        start = op_count;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            want = ref_prod(a, b);
            do_accept(a, b, ok);
            n = 0;
            while (!out_valid && n < 40) begin
                out_ready = 1'($urandom);
                @(posedge clk); #1;
                n++;
            end
            out_ready = 1'b0;
            n_vec++;
            if (!ok || n != EXPL) begin
                n_miss++;
                $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, n, EXPL);
            end
            d = $urandom_range(0, 3);
            repeat (d) @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_p !== want) begin
                n_miss++;
                $display("FAIL rnd_product[%0d]: %h*%h got %h want %h", i, a, b, out_p, want);
            end
            handshake();
            n_vec++;
            if (out_valid !== 1'b0 || op_count !== exp_count) begin
                n_miss++;
                $display("FAIL rnd_done[%0d]: ov=%b cnt=%h want 0 %h",
                         i, out_valid, op_count, exp_count);
            end
        end
        n_vec++;
        if (op_count - start !== 16'd300) begin
            n_miss++;
            $display("FAIL rnd_total: got %0d want 300", op_count - start);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b0;
        exp_count = 16'd0;
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
